mem_stage: RTL and testbench

Memory-access stage of the 32-bit pipeline. Consumes the EX/MEM pipeline register outputs, performs loads and stores over a req/ack data-memory handshake, and resolves branches. It holds the pipeline with `stall` while a memory access is outstanding and owns the MEM/WB pipeline register feeding write-back and the forwarding unit.

---
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 32-bit pipeline: req/ack data-memory handshake with
// timeout, branch resolution, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Mem_WB,
    input  logic        read_En,
    input  logic        write_En,
    input  logic        Mem_Br,
    input  logic        Zero,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    input  logic [4:0]  dest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        PCSrc,
    output logic [1:0]  WB,
    output logic [31:0] ReadData,
    output logic [31:0] ALUResult,
    output logic [4:0]  Write_Register,
    output logic        RegWrite,
    output logic        mem_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        mem_we_r, mem_we_nxt_s;
    logic [31:0] mem_addr_r, mem_addr_nxt_s;
    logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [1:0]  lat_wb_r, lat_wb_nxt_s;
    logic [4:0]  lat_dest_r, lat_dest_nxt_s;
    logic [1:0]  wb_r, wb_nxt_s;
    logic [31:0] rdata_r, rdata_nxt_s;
    logic [31:0] alu_r, alu_nxt_s;
    logic [4:0]  wr_r, wr_nxt_s;
    logic        err_r, err_nxt_s;
    logic        access_s, in_access_s, ack_s, timeout_s;

    // A simultaneous read and write is a store; the read request is dropped.
    assign access_s    = read_En | write_En;
    assign in_access_s = (state_r == ACCESS);
    assign ack_s       = in_access_s & mem_ack;
    assign timeout_s   = in_access_s & ~mem_ack & (cnt_r == LAST_WAIT);

    // Next-state and next MEM/WB contents; everything holds unless updated.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        lat_wb_nxt_s    = lat_wb_r;
        lat_dest_nxt_s  = lat_dest_r;
        wb_nxt_s        = wb_r;
        rdata_nxt_s     = rdata_r;
        alu_nxt_s       = alu_r;
        wr_nxt_s        = wr_r;
        err_nxt_s       = err_r;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    mem_addr_nxt_s  = DataAddress;
                    mem_wdata_nxt_s = WriteData;
                    mem_we_nxt_s    = write_En;
                    lat_wb_nxt_s    = Mem_WB;
                    lat_dest_nxt_s  = dest;
                    wb_nxt_s        = 2'b00;
                    wr_nxt_s        = 5'd0;
                    alu_nxt_s       = 32'd0;
                    cnt_nxt_s       = 8'd0;
                    state_nxt_s     = ACCESS;
                end else begin
                    wb_nxt_s  = Mem_WB;
                    alu_nxt_s = DataAddress;
                    wr_nxt_s  = dest;
                end
            end
            ACCESS: begin
                if (ack_s) begin
                    if (!mem_we_r) begin
                        rdata_nxt_s = mem_rdata;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                    wb_nxt_s    = lat_wb_r;
                    alu_nxt_s   = mem_addr_r;
                    wr_nxt_s    = lat_dest_r;
                    state_nxt_s = IDLE;
                end else if (timeout_s) begin
                    // Aborted access retires with write-back disabled.
                    wb_nxt_s    = 2'b00;
                    rdata_nxt_s = 32'd0;
                    alu_nxt_s   = mem_addr_r;
                    wr_nxt_s    = lat_dest_r;
                    err_nxt_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, latched request and MEM/WB register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            lat_wb_r    <= 2'b00;
            lat_dest_r  <= 5'd0;
            wb_r        <= 2'b00;
            rdata_r     <= 32'd0;
            alu_r       <= 32'd0;
            wr_r        <= 5'd0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            lat_wb_r    <= lat_wb_nxt_s;
            lat_dest_r  <= lat_dest_nxt_s;
            wb_r        <= wb_nxt_s;
            rdata_r     <= rdata_nxt_s;
            alu_r       <= alu_nxt_s;
            wr_r        <= wr_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    // Stall drops in the completing cycle so EX/MEM advances as MEM/WB captures.
    assign stall          = (~in_access_s & access_s) | (in_access_s & ~ack_s & ~timeout_s);
    assign PCSrc          = Mem_Br & Zero & ~in_access_s;
    assign mem_req        = in_access_s;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign WB             = wb_r;
    assign ReadData       = rdata_r;
    assign ALUResult      = alu_r;
    assign Write_Register = wr_r;
    assign RegWrite       = wb_r[1];
    assign mem_err        = err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  Mem_WB;
    logic        read_En, write_En, Mem_Br, Zero;
    logic [31:0] DataAddress, WriteData;
    logic [4:0]  dest;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        stall, PCSrc;
    logic [1:0]  WB;
    logic [31:0] ReadData, ALUResult;
    logic [4:0]  Write_Register;
    logic        RegWrite, mem_err;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
        .Mem_Br(Mem_Br), .Zero(Zero), .DataAddress(DataAddress), .WriteData(WriteData),
        .dest(dest), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .PCSrc(PCSrc), .WB(WB), .ReadData(ReadData), .ALUResult(ALUResult),
        .Write_Register(Write_Register), .RegWrite(RegWrite), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one outstanding transaction plus the visible MEM/WB contents.
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_done  = 0;
    int          cur_lat = 1;
    bit          rand_mode = 1'b0;
    logic [31:0] t_addr, t_wdata;
    logic        t_store;
    logic [1:0]  t_wb;
    logic [4:0]  t_dest;
    logic [1:0]  m_wb;
    logic [31:0] m_rd, m_alu;
    logic [4:0]  m_wr;
    logic        m_err;

    logic        s_stall, s_req, s_pcsrc, s_we;
    logic [31:0] s_addr, s_wdata;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 0;
        t_addr = 32'd0; t_wdata = 32'd0; t_store = 1'b0; t_wb = 2'b00; t_dest = 5'd0;
        m_wb = 2'b00; m_rd = 32'd0; m_alu = 32'd0; m_wr = 5'd0; m_err = 1'b0;
        m_known = 1'b1;
    endtask

    // One clock cycle: drive memory response, compare all outputs, advance model.
    task automatic cycle();
        int   nth;
        logic fin, exp_stall;
        nth = m_done + 1;
        if (m_busy) mem_ack = (nth == cur_lat);
        else if (rand_mode) mem_ack = ($urandom_range(0, 3) == 0);
        else mem_ack = 1'b0;
        if (rand_mode) mem_rdata = $urandom();
        if (!m_busy && rand_mode && (read_En || write_En)) cur_lat = $urandom_range(1, TMO + 2);
        @(negedge clk);
        #1;
        s_stall = stall; s_req = mem_req; s_pcsrc = PCSrc; s_we = mem_we;
        s_addr = mem_addr; s_wdata = mem_wdata;
        if (m_known) begin
            fin       = m_busy && (mem_ack || nth == TMO);
            exp_stall = m_busy ? !fin : (read_En | write_En);
            chk("stall", stall, exp_stall);
            chk("PCSrc", PCSrc, Mem_Br & Zero & !m_busy);
            chk("mem_req", mem_req, m_busy);
            chk("mem_we", mem_we, t_store);
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_wdata", mem_wdata, t_wdata);
            chk("WB", WB, m_wb);
            chk("RegWrite", RegWrite, m_wb[1]);
            chk("ReadData", ReadData, m_rd);
            chk("ALUResult", ALUResult, m_alu);
            chk("Write_Register", Write_Register, m_wr);
            chk("mem_err", mem_err, m_err);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_known) begin
            if (!m_busy) begin
                if (read_En || write_En) begin
                    t_addr = DataAddress; t_wdata = WriteData; t_store = write_En;
                    t_wb = Mem_WB; t_dest = dest;
                    m_wb = 2'b00; m_wr = 5'd0; m_alu = 32'd0;
                    m_busy = 1'b1; m_done = 0;
                end else begin
                    m_wb = Mem_WB; m_alu = DataAddress; m_wr = dest;
                end
            end else if (mem_ack) begin
                if (!t_store) m_rd = mem_rdata;
                m_wb = t_wb; m_alu = t_addr; m_wr = t_dest;
                m_busy = 1'b0;
            end else if (nth == TMO) begin
                m_wb = 2'b00; m_rd = 32'd0; m_alu = t_addr; m_wr = t_dest;
                m_err = 1'b1; m_busy = 1'b0;
            end else begin
                m_done = nth;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        read_En = 1'b0; write_En = 1'b0; Mem_WB = 2'b00;
        DataAddress = 32'd0; WriteData = 32'd0; dest = 5'd0;
    endtask

    task automatic rand_inputs();
        Mem_WB = 2'($urandom_range(0, 3));
        read_En = ($urandom_range(0, 3) == 0);
        write_En = ($urandom_range(0, 4) == 0);
        Mem_Br = ($urandom_range(0, 3) == 0);
        Zero = 1'($urandom_range(0, 1));
        DataAddress = $urandom(); WriteData = $urandom();
        dest = 5'($urandom_range(0, 31));
    endtask

    int n_st, n_rq;
    logic last_stall;

    initial begin
        rst = 1'b1; Mem_Br = 1'b0; Zero = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        clear_inputs();

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            cycle();
        end
        chk("rst_WB", WB, 32'd0);
        chk("rst_ReadData", ReadData, 32'd0);
        chk("rst_ALUResult", ALUResult, 32'd0);
        chk("rst_Write_Register", Write_Register, 32'd0);
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_mem_err", mem_err, 32'd0);
        rst = 1'b0; Mem_Br = 1'b0; Zero = 1'b0;
        clear_inputs();
        cycle();

        // Pass-through ALU op
        Mem_WB = 2'b10; DataAddress = 32'h0000_1234; dest = 5'd5;
        cycle();
        chk("pt_stall", s_stall, 32'd0);
        chk("pt_WB", WB, 32'd2);
        chk("pt_ALUResult", ALUResult, 32'h0000_1234);
        chk("pt_Write_Register", Write_Register, 32'd5);
        chk("pt_RegWrite", RegWrite, 32'd1);

        // Load, ack on the 3rd request cycle
        clear_inputs();
        read_En = 1'b1; Mem_WB = 2'b11; DataAddress = 32'h40; dest = 5'd9;
        mem_rdata = 32'hCAFE_F00D; cur_lat = 3;
        cycle();
        n_st = int'(s_stall); n_rq = int'(s_req);
        chk("ld_bubble_WB", WB, 32'd0);
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_st += int'(s_stall); n_rq += int'(s_req);
            chk("ld_addr", s_addr, 32'h40);
            chk("ld_we", s_we, 32'd0);
        end
        chk("ld_ReadData", ReadData, 32'hCAFE_F00D);
        chk("ld_WB", WB, 32'd3);
        chk("ld_Write_Register", Write_Register, 32'd9);
        cycle();
        n_rq += int'(s_req);
        chk("ld_stall_cycles", n_st, 32'd3);
        chk("ld_req_cycles", n_rq, 32'd3);

        // Store with read also set, ack in first access cycle
        read_En = 1'b1; write_En = 1'b1; DataAddress = 32'h80; WriteData = 32'hA5A5_A5A5;
        mem_rdata = 32'h1111_1111; cur_lat = 1;
        cycle();
        chk("st_stall_idle", s_stall, 32'd1);
        clear_inputs();
        cycle();
        chk("st_req", s_req, 32'd1);
        chk("st_we", s_we, 32'd1);
        chk("st_wdata", s_wdata, 32'hA5A5_A5A5);
        chk("st_stall_done", s_stall, 32'd0);
        chk("st_ReadData", ReadData, 32'hCAFE_F00D);
        cycle();
        chk("st_req_after", s_req, 32'd0);

        // Timeout: load never acknowledged
        read_En = 1'b1; Mem_WB = 2'b11; DataAddress = 32'h100; dest = 5'd7; cur_lat = 100;
        cycle();
        clear_inputs();
        n_rq = 0; last_stall = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            cycle();
            n_rq += int'(s_req); last_stall = s_stall;
        end
        chk("to_last_stall", last_stall, 32'd0);
        chk("to_mem_err", mem_err, 32'd1);
        chk("to_WB", WB, 32'd0);
        chk("to_ReadData", ReadData, 32'd0);
        chk("to_ALUResult", ALUResult, 32'h100);
        chk("to_Write_Register", Write_Register, 32'd7);
        cycle();
        n_rq += int'(s_req);
        chk("to_req_cycles", n_rq, TMO);
        Mem_WB = 2'b10; DataAddress = 32'h77; dest = 5'd3;
        cycle();
        chk("to_alu_stall", s_stall, 32'd0);
        chk("to_alu_WB", WB, 32'd2);
        chk("to_alu_ALUResult", ALUResult, 32'h77);
        chk("to_err_sticky", mem_err, 32'd1);

        // Branch resolution, then reset during access with simultaneous ack
        clear_inputs();
        Mem_Br = 1'b1; Zero = 1'b1;
        cycle();
        chk("br_taken", s_pcsrc, 32'd1);
        Zero = 1'b0;
        cycle();
        chk("br_not_taken", s_pcsrc, 32'd0);
        Zero = 1'b1; read_En = 1'b1; DataAddress = 32'h200; Mem_WB = 2'b11; dest = 5'd4;
        mem_rdata = 32'hDEAD_BEEF; cur_lat = 2;
        cycle();
        chk("br_idle_access", s_pcsrc, 32'd1);
        read_En = 1'b0;
        cycle();
        chk("br_in_access", s_pcsrc, 32'd0);
        chk("br_req", s_req, 32'd1);
        rst = 1'b1;
        cycle();
        chk("ra_mem_req", mem_req, 32'd0);
        chk("ra_WB", WB, 32'd0);
        chk("ra_ReadData", ReadData, 32'd0);
        chk("ra_ALUResult", ALUResult, 32'd0);
        chk("ra_Write_Register", Write_Register, 32'd0);
        chk("ra_mem_err", mem_err, 32'd0);
        rst = 1'b0; Mem_Br = 1'b0; Zero = 1'b0;
        clear_inputs();
        cycle();

        // Randomized traffic against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
